// File: rtl/return_stack_pkg.sv
// -----------------------------------------------------------------------------
// return_stack_pkg
// Shared CPU constants used by the return stack and the control unit:
//   PC_W         - program-counter / return-address width
//   STACK_DEPTH  - default number of return-stack entries
//   OPC_PUSH/POP - opcodes the control unit decodes into push/pop strobes
//   stack_op_e   - per-cycle operation resolved from the push/pop strobes
// -----------------------------------------------------------------------------
package return_stack_pkg;

  localparam int PC_W        = 10;
  localparam int STACK_DEPTH = 16;

  localparam logic [5:0] OPC_PUSH = 6'b111000;
  localparam logic [5:0] OPC_POP  = 6'b111100;

  // Push+pop on an empty stack resolves to SOP_PUSH; there is nothing to replace.
  typedef enum logic [1:0] {
    SOP_IDLE,
    SOP_PUSH,
    SOP_POP,
    SOP_REPLACE
  } stack_op_e;

endpackage

// File: rtl/return_stack_if.sv
// -----------------------------------------------------------------------------
// return_stack_if
// Control-unit <-> return-stack signal bundle.
//   push, pop, ret_in            : control unit -> stack
//   ret_out, count, empty, full,
//   overflow, underflow          : stack -> control unit / PC mux
// master: control unit side.  slave: return stack side.
// -----------------------------------------------------------------------------
interface return_stack_if
  import return_stack_pkg::*;
#(
  parameter int AW    = PC_W,
  parameter int DEPTH = STACK_DEPTH
);

  logic                     push;
  logic                     pop;
  logic [AW-1:0]            ret_in;
  logic [AW-1:0]            ret_out;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;
  logic                     full;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output push, pop, ret_in,
    input  ret_out, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, ret_in,
    output ret_out, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/return_stack_stack_mem.sv
// -----------------------------------------------------------------------------
// stack_mem
// DEPTH x AW register file for the return stack.
//   clk   in  : write clock
//   we    in  : write enable
//   waddr in  : write index
//   wdata in  : write data
//   raddr in  : read index
//   rdata out : asynchronous read data
// Entries are deliberately not reset; the stack pointer alone defines validity.
// -----------------------------------------------------------------------------
module stack_mem #(
  parameter int AW    = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// -----------------------------------------------------------------------------
// return_stack
// Hardware call/return stack for the CPU.
//   clk   in : rising-edge clock
//   reset in : asynchronous active-low reset (clears pointer and sticky flags)
//   rs        : return_stack_if.slave
//     push/pop/ret_in   - call/return strobes and return address
//     ret_out           - current top entry, zero-latency, zero when empty
//     count/empty/full  - occupancy, decoded from the stack pointer
//     overflow          - sticky, push attempted while full (no pop)
//     underflow         - sticky, pop attempted while empty
// -----------------------------------------------------------------------------
module return_stack
  import return_stack_pkg::*;
#(
  parameter int AW    = PC_W,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  return_stack_if.slave rs
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;

  logic [SW-1:0] sp;
  logic [SW-1:0] sp_nxt;
  logic          ovf;
  logic          ovf_nxt;
  logic          unf;
  logic          unf_nxt;
  logic          empty;
  logic          full;
  stack_op_e     op;
  logic          we;
  logic [IW-1:0] waddr;
  logic [IW-1:0] top_idx;
  logic [AW-1:0] rdata;

  assign empty   = (sp == '0);
  assign full    = (sp == SW'(DEPTH));
  assign top_idx = IW'(sp - SW'(1));

  always_comb begin
    op = SOP_IDLE;
    unique case ({rs.push, rs.pop})
      2'b10:   op = SOP_PUSH;
      2'b01:   op = SOP_POP;
      2'b11:   op = empty ? SOP_PUSH : SOP_REPLACE;
      default: op = SOP_IDLE;
    endcase
  end

  // Any pop seen while empty is an underflow, with or without a push.
  always_comb begin
    sp_nxt  = sp;
    ovf_nxt = ovf;
    unf_nxt = unf | (rs.pop & empty);
    we      = 1'b0;
    waddr   = sp[IW-1:0];
    unique case (op)
      SOP_PUSH: begin
        if (!full) begin
          we     = 1'b1;
          sp_nxt = sp + SW'(1);
        end else begin
          ovf_nxt = 1'b1;
        end
      end
      SOP_POP: begin
        if (!empty) begin
          sp_nxt = sp - SW'(1);
        end
      end
      SOP_REPLACE: begin
        we    = 1'b1;
        waddr = top_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp  <= sp_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end

  stack_mem #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (rs.ret_in),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign rs.ret_out   = empty ? '0 : rdata;
  assign rs.count     = sp;
  assign rs.empty     = empty;
  assign rs.full      = full;
  assign rs.overflow  = ovf;
  assign rs.underflow = unf;

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 Parameter AW, default 10: return-address width, equal to the PC width.
REQ-002 Parameter DEPTH, default 16: number of entries, a power of two, at least 2.
REQ-003 Clocking is fixed: one clock, clk; reset is asynchronous and active-low, port reset.
REQ-004 clk  in  1  rising-edge clock shared with the CPU datapath.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 push  in  1  from the control unit: store ret_in on this edge (call).
REQ-007 pop  in  1  from the control unit: remove the top entry on this edge (return).
REQ-008 ret_in  in  AW  return address to store (PC+1 from the incrementer).
REQ-009 ret_out  out  AW  current top entry, combinational, for the PC mux selected by s_stack.
REQ-010 count  out  log2(DEPTH)+1  number of valid entries.
REQ-011 empty  out  1  high when count==0.
REQ-012 full  out  1  high when count==DEPTH.
REQ-013 overflow  out  1  sticky: a push was attempted while full.
REQ-014 underflow  out  1  sticky: a pop was attempted while empty.

Function
REQ-015 Storage: DEPTH x AW registers plus a stack pointer sp equal to count; sp points to the next free slot.
REQ-016 Read latency is zero: ret_out = mem[sp-1] while !empty, and all-zero when empty, so a return instruction loads the PC in the same cycle.
REQ-017 Push only, !full: mem[sp] <= ret_in; sp <= sp+1.
REQ-018 Pop only, !empty: sp <= sp-1; entry contents are not cleared.
REQ-019 Push and pop together, !empty: mem[sp-1] <= ret_in; sp is unchanged.
  - ret_out shows the old top during that cycle.
REQ-020 Push and pop together while empty: behave as push only; underflow <= 1.
REQ-021 Push while full, no pop: the write and sp are suppressed; overflow <= 1; contents are preserved.
REQ-022 Push and pop together while full: handled by REQ-019; overflow is not set.
REQ-023 Pop while empty, no push: sp stays 0; underflow <= 1; ret_out stays 0.
REQ-024 sp never wraps: it is saturating bookkeeping only, limited to 0..DEPTH.
REQ-025 overflow and underflow remain set until reset; there is no other clear path.
REQ-026 With push=pop=0 all state holds; ret_in is ignored.
REQ-027 empty and full are decoded combinationally from sp, not registered separately.

Reset
REQ-028 reset low, asynchronously: sp=0, overflow=0, underflow=0.
  - Outputs then read empty=1, full=0, count=0, ret_out=0.
REQ-029 Entry registers are not reset; their values are unobservable while the stack is empty.
REQ-030 Reset asserted mid-sequence discards all entries immediately, regardless of push/pop.
REQ-031 Operation resumes on the first rising clk after reset deasserts.

Structure
REQ-032 The shared CPU package holds:
  - PC width constant (AW default);
  - default stack DEPTH;
  - opcode constants for push (111000) and pop (111100) used by the control unit.
REQ-033 A single sub-module, stack_mem, is natural:
  - DEPTH x AW register file, one synchronous write port, one asynchronous read port, no reset.
REQ-034 Pointer, flag and next-state logic live in return_stack; no other hierarchy.

Verification (DEPTH=4, AW=10)
REQ-035 Reset, then idle -> empty=1, count=0, ret_out=0, overflow=0, underflow=0.
REQ-036 Push 0x011, 0x022, 0x033 -> count=3, ret_out=0x033.
  - Then pop x3 -> ret_out 0x033, 0x022, 0x011 in the cycles of the pops; empty=1 afterwards.
REQ-037 Push 0x001..0x004 -> full=1.
  - Push 0x3FF -> overflow=1, count=4, ret_out=0x004.
  - Then push+pop with 0x155 -> ret_out=0x155, count=4.
REQ-038 Pop while empty -> underflow=1, count=0.
  - Then push+pop with 0x0AA -> count=1, ret_out=0x0AA.
REQ-039 Push 0x100, 0x200, then assert reset low between edges -> count=0 and empty=1 immediately, without a clock edge.
REQ-040 Random push/pop/ret_in for 2000 cycles -> ret_out, count and flags match a queue reference model every cycle.
